pe_gram_row_stream: RTL

//  Streaming parametrised Gram-row engine for the ICA datapath. Computes p[k] = sum_t u[k][t]*u[r][t]
//  for every channel k against one runtime-selected reference channel r.

---
 rtl/pe_gram_row_stream.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pe_gram_row_stream.sv
// Streaming Gram-row engine: p[k] = sum_t u[k][t]*u[r][t], one column per beat.
// Define ACC_SAT_EN to clamp accumulators on signed overflow instead of wrapping.
module pe_gram_row_stream #(
  parameter int N_CH   = 3,
  parameter int DATA_W = 32,
  parameter int LEN    = 64,
  parameter int ACC_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(N_CH)-1:0]    ref_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CH*DATA_W-1:0]     u_col,
  output logic [N_CH*ACC_W-1:0]      p,
  output logic                       p_valid,
  input  logic                       p_ready,
  output logic                       busy,
  output logic [N_CH-1:0]            ovf,
  output logic                       cfg_err
);

  localparam int RW = $clog2(N_CH);
  localparam int CW = $clog2(LEN + 1);
  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0]          ref_q;
  logic [CW-1:0]          cnt_q;
  logic                   cfg_err_q, cfg_err_d;
  logic                   p_valid_q, p_valid_d;
  logic                   prod_vld_q;
  logic signed [PW-1:0]   prod_q [N_CH];
  logic signed [PW-1:0]   prod_d [N_CH];
  logic [ACC_W-1:0]       acc_q  [N_CH];
  logic [ACC_W-1:0]       acc_d  [N_CH];
  logic [N_CH-1:0]        ovf_q, of_d;

  logic                   ref_ok;
  logic                   start_ok;
  logic                   beat;
  logic                   last_beat;
  logic [DATA_W-1:0]      uref;
  logic signed [PW-1:0]   ax, bx;
  logic [ACC_W-1:0]       ext, sum;

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  assign ref_ok    = (32'(ref_sel) < 32'(N_CH));
  assign in_ready  = (state_q == S_ACCUM);
  assign beat      = in_valid && in_ready;
  assign last_beat = (cnt_q == CW'(LEN - 1));
  assign busy      = (state_q != S_IDLE);
  assign p_valid   = p_valid_q;
  assign cfg_err   = cfg_err_q;
  assign ovf       = ovf_q;

  always_comb begin
    p = '0;
    for (int k = 0; k < N_CH; k++) begin
      p[k*ACC_W +: ACC_W] = acc_q[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    cfg_err_d = 1'b0;
    p_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ref_ok) begin
            state_d  = S_ACCUM;
            start_ok = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (beat && last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (p_valid_q && p_ready) begin
          state_d = S_IDLE;
        end else begin
          p_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1: full-precision products against the latched reference channel
  always_comb begin
    ax   = '0;
    uref = u_col[ref_q*DATA_W +: DATA_W];
    bx   = {{DATA_W{uref[DATA_W-1]}}, uref};
    for (int k = 0; k < N_CH; k++) begin
      ax = {{DATA_W{u_col[k*DATA_W+DATA_W-1]}},
            u_col[k*DATA_W +: DATA_W]};
      prod_d[k] = ax * bx;
    end
  end

  // Stage 2: sign-extend and accumulate, flag overflow by sign rule
  always_comb begin
    ext  = '0;
    sum  = '0;
    of_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      ext = ACC_W'(prod_q[k]);
      sum = acc_q[k] + ext;
      of_d[k] = (acc_q[k][ACC_W-1] == ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc_q[k][ACC_W-1]);
`ifdef ACC_SAT_EN
      if (of_d[k]) begin
        acc_d[k] = ext[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
        acc_d[k] = sum;
      end
`else
      acc_d[k] = sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ref_q      <= '0;
      cnt_q      <= '0;
      cfg_err_q  <= 1'b0;
      p_valid_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      ovf_q      <= '0;
      for (int k = 0; k < N_CH; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cfg_err_q  <= cfg_err_d;
      p_valid_q  <= p_valid_d;
      prod_vld_q <= beat;
      if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        for (int k = 0; k < N_CH; k++) begin
          prod_q[k] <= prod_d[k];
        end
      end
      if (start_ok) begin
        ref_q <= ref_sel;
        cnt_q <= '0;
        ovf_q <= '0;
        for (int k = 0; k < N_CH; k++) begin
          acc_q[k] <= '0;
        end
      end else if (prod_vld_q) begin
        ovf_q <= ovf_q | of_d;
        for (int k = 0; k < N_CH; k++) begin
          acc_q[k] <= acc_d[k];
        end
      end
    end
  end

endmodule
